// File: rtl/univ_shift_seq_pkg.sv
// Shared definitions for the universal shift sequencer: mode codes, FSM states
// and a legality helper used when an operation is accepted.
package univ_shift_seq_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Codes 110/111 are reserved: they complete the handshake but leave q alone.
  function automatic logic is_shift_mode(input logic [MODE_W-1:0] mode);
    return (mode != MODE_LOAD) && (mode <= MODE_ROL);
  endfunction

endpackage

// File: rtl/univ_shift_seq_if.sv
// Controller-facing bundle of the shift sequencer: operation request on one
// side, register contents, handshake and status flags on the other.
interface univ_shift_seq_if #(
  parameter int N  = 8,
  parameter int CW = 4
);
  logic          en;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] amount;
  logic [N-1:0]  d_in;
  logic          ser_in;

  logic [N-1:0]  q;
  logic          busy;
  logic          done;
  logic          zero;
  logic          lsb;
  logic          msb;

  modport master (
    output en, start, mode, amount, d_in, ser_in,
    input  q, busy, done, zero, lsb, msb
  );

  modport slave (
    input  en, start, mode, amount, d_in, ser_in,
    output q, busy, done, zero, lsb, msb
  );
endinterface

// File: rtl/univ_shift_step.sv
// Single-position step of the universal shifter; purely combinational.
// LOAD and reserved codes pass the register through unchanged.
module univ_shift_step
  import univ_shift_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]      q,
  input  logic [MODE_W-1:0] mode,
  input  logic              ser_in,
  output logic [N-1:0]      q_next
);

  always_comb begin
    // NOTE: default first so every path assigns q_next and no latch is inferred.
    q_next = q;
    case (mode)
      MODE_SHR: q_next = {ser_in, q[N-1:1]};
      MODE_SHL: q_next = {q[N-2:0], ser_in};
      MODE_ASR: q_next = {q[N-1], q[N-1:1]};
      MODE_ROR: q_next = {q[0], q[N-1:1]};
      MODE_ROL: q_next = {q[N-2:0], q[N-1]};
      default:  q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_seq.sv
// Universal shift register with a start/busy/done sequencer that applies one
// single-bit step of the latched mode per enabled cycle.
module univ_shift_seq
  import univ_shift_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic             clk,
  input  logic             clr,
  univ_shift_seq_if.slave  bus
);

  state_t            state, state_n;
  logic [N-1:0]      q_r, q_n;
  logic [CW-1:0]     count, count_n;
  logic [MODE_W-1:0] mode_r, mode_n;
  logic [N-1:0]      step_q;

  univ_shift_step #(.N(N)) u_step (
    .q      (q_r),
    .mode   (mode_r),
    .ser_in (bus.ser_in),
    .q_next (step_q)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= ST_IDLE;
      q_r    <= '0;
      count  <= '0;
      mode_r <= MODE_LOAD;
    end else begin
      // NOTE: non-blocking so all state updates see pre-edge values.
      state  <= state_n;
      q_r    <= q_n;
      count  <= count_n;
      mode_r <= mode_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q_r;
    count_n = count;
    mode_n  = mode_r;
    case (state)
      ST_IDLE: begin
        if (bus.en && bus.start) begin
          mode_n = bus.mode;
          if (bus.mode == MODE_LOAD) begin
            q_n     = bus.d_in;
            state_n = ST_DONE;
          end else if (bus.amount == '0 || !is_shift_mode(bus.mode)) begin
            state_n = ST_DONE;
          end else begin
            count_n = bus.amount;
            state_n = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // en low freezes q, count and state together.
        if (bus.en) begin
          q_n     = step_q;
          count_n = count - CW'(1);
          if (count == CW'(1)) state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.q    = q_r;
  assign bus.busy = (state != ST_IDLE);
  assign bus.done = (state == ST_DONE);
  assign bus.zero = (q_r == '0);
  assign bus.lsb  = q_r[0];
  assign bus.msb  = q_r[N-1];

endmodule

// File: doc/univ_shift_seq.md
Name: univ_shift_seq

Overview:
Parametrised universal shift register with a multi-cycle shift sequencer, replacing the single-mode load/shift-right register in our shift-add datapaths.
Supports parallel load, logical/arithmetic shifts and rotates by a programmable amount, one bit position per enabled cycle.
Uses a start/busy/done handshake so a controller FSM can issue an operation and wait.
Provides zero/lsb/msb status flags for multiplier and divider control logic.

Parameters:
N, 8, data width in bits (N >= 2)
CW, 4, width of the shift-amount input; must satisfy 2^CW - 1 >= N

Ports:
clk  input  1  system clock; all state updates on rising edge
clr  input  1  asynchronous active-high reset
en  input  1  global enable; gates start acceptance and RUN progress
start  input  1  request an operation; sampled only in IDLE with en=1
mode  input  3  operation code, latched at accept
amount  input  CW  number of single-bit shift steps, latched at accept
d_in  input  N  parallel load data, used only by LOAD
ser_in  input  1  serial fill bit for SHR/SHL, sampled live on every shift edge
q  output  N  register contents
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle pulse in DONE state
zero  output  1  combinational, 1 when q == 0
lsb  output  1  combinational q[0]
msb  output  1  combinational q[N-1]

Behaviour:
- Reset (clr=1, asynchronous, overrides everything): q=0, state=IDLE, count=0, latched mode=LOAD, busy=0, done=0; zero=1 follows.
- Mode codes:
  - 000 LOAD: q <= d_in, no shifting.
  - 001 SHR: fill MSB with ser_in.
  - 010 SHL: fill LSB with ser_in.
  - 011 ASR: replicate MSB.
  - 100 ROR.
  - 101 ROL.
  - 110/111 illegal: q unchanged, full handshake still completes.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1 and en=1, latch mode, and:
  - LOAD: q <= d_in on that edge; go to DONE.
  - amount==0 or illegal mode: q unchanged; go to DONE.
  - otherwise: count <= amount; go to RUN.
  - With start=0 or en=0: stay in IDLE, q holds.
- RUN: on each edge with en=1, q takes one step of the latched mode and count decrements. The edge where count==1 performs the last step and moves to DONE. With en=0, q, count and state freeze.
- DONE: done=1 for exactly one cycle; unconditional return to IDLE on the next edge, regardless of en.
- Latency: done is high in the cycle following the k-th enabled shift edge after accept, where k = max(amount,1) and LOAD/illegal count as k=1. Without stalls this is k cycles after the accept edge.
- start while busy=1 is ignored; it is not queued.
- amount >= N is legal and performs exactly amount steps, e.g. SHR by N with ser_in=0 gives q=0 and ROR by N restores q.
- mode, amount and d_in may change after accept without effect. ser_in is not latched.
- clr asserted mid-RUN aborts immediately and no done pulse is produced. Release of clr is synchronous to the design by assumption of the reset synchroniser upstream.

Decomposition:
- Shared package holds:
  - mode localparams MODE_LOAD, MODE_SHR, MODE_SHL, MODE_ASR, MODE_ROR, MODE_ROL;
  - state encoding ST_IDLE, ST_RUN, ST_DONE.
- Sub-module univ_shift_step (combinational, parametrised N): inputs q, mode, ser_in; output the next single-step value. Instantiated once; the sequencer FSM and counter stay in the top module.

Test Plan:
- N=8, start mode=LOAD d_in=0xA5 -> q=0xA5 after accept edge, done pulses 1 cycle, busy high 1 cycle, zero=0.
- From q=0xA5, SHR amount=3 ser_in=0 -> q=0x52,0x29,0x14 on successive edges, done in 4th cycle, lsb=0, msb=0.
- From q=0x90, ASR amount=2 -> q=0xE4. From q=0x81, ROL amount=3 -> q=0x0C. Illegal mode 111 -> q unchanged, done after 1 cycle.
- From q=0x01, SHL amount=4 with en low for 2 cycles after second step -> q=0x04 held during stall, final q=0x10, done delayed by 2 cycles. A start during RUN is ignored.
- clr pulsed mid-RUN (count=2) -> q=0, busy=0, zero=1 immediately without waiting for clk, and no done pulse. A fresh LOAD afterwards works normally.
- amount=0 with SHR -> q unchanged, done in next cycle. SHR amount=8 ser_in=1 from 0x00 -> q=0xFF after 8 steps.
